// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with transaction watchdog
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_ack,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_ack,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_grant
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    state_t            state, state_d;
    logic              last_grant, last_grant_d;
    logic              grant_d;
    logic [TMO_W-1:0]  cnt, cnt_d, cnt_inc;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              m0_ack_d, m1_ack_d, err_d;
    logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;
    logic              pick, done, timed_out;
    logic [DATA_W-1:0] done_rdata;

    // Watchdog saturates instead of wrapping.
    always_comb begin
        cnt_inc = (cnt == TMO_MAX) ? cnt : cnt + 1'b1;
    end

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = o_grant;
        cnt_d        = cnt;
        mem_req_d    = o_mem_req;
        mem_we_d     = o_mem_we;
        mem_addr_d   = o_mem_addr;
        mem_wdata_d  = o_mem_wdata;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = '0;
        m1_rdata_d   = '0;
        err_d        = 1'b0;
        pick         = 1'b0;
        done         = 1'b0;
        timed_out    = 1'b0;
        done_rdata   = '0;

        case (state)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    pick        = (i_m0_req && i_m1_req) ? ~last_grant : i_m1_req;
                    grant_d     = pick;
                    mem_we_d    = pick ? i_m1_we    : i_m0_we;
                    mem_addr_d  = pick ? i_m1_addr  : i_m0_addr;
                    mem_wdata_d = pick ? i_m1_wdata : i_m0_wdata;
                    mem_req_d   = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready is tested first so it wins over a same-cycle timeout.
                if (i_mem_ready) begin
                    done       = 1'b1;
                    done_rdata = o_mem_we ? '0 : i_mem_rdata;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_MAX) begin
                        done      = 1'b1;
                        timed_out = 1'b1;
                    end
                end
                if (done) begin
                    mem_req_d  = 1'b0;
                    err_d      = timed_out;
                    m0_ack_d   = ~o_grant;
                    m1_ack_d   = o_grant;
                    m0_rdata_d = o_grant ? '0 : done_rdata;
                    m1_rdata_d = o_grant ? done_rdata : '0;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                last_grant_d = o_grant;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            o_grant     <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_m0_ack    <= 1'b0;
            o_m1_ack    <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            cnt         <= cnt_d;
            o_grant     <= grant_d;
            o_mem_req   <= mem_req_d;
            o_mem_we    <= mem_we_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
            o_m0_ack    <= m0_ack_d;
            o_m1_ack    <= m1_ack_d;
            o_m0_rdata  <= m0_rdata_d;
            o_m1_rdata  <= m1_rdata_d;
            o_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized bench for bus_arbiter against a transaction-timing model
module tb_bus_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TW      = 4;
    localparam int TMO_LIM = (1 << TW) - 1;
    localparam int N_TXN   = 80;
    localparam int MAX_CYC = 20000;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [AW-1:0] i_m0_addr, i_m1_addr;
    logic [DW-1:0] i_m0_wdata, i_m1_wdata;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata;
    logic          o_m0_ack, o_m1_ack, o_err;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          o_grant;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .o_m0_rdata(o_m0_rdata), .o_m0_ack(o_m0_ack),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .o_m1_rdata(o_m1_rdata), .o_m1_ack(o_m1_ack),
        .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .o_grant(o_grant)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    // Master-side request state
    bit        pend [2];
    bit        m_we [2];
    bit [31:0] m_addr [2];
    bit [31:0] m_wdata [2];

    // In-flight transaction, described by the cycles at which events must occur
    bit        busy;
    int        owner, issue_c, ready_c, ack_c;
    bit        t_we, t_err;
    bit [31:0] t_addr, t_wdata, t_rdata;
    int        last_g, exp_grant, free_at, n_done, n_issued, j;
    bit        rst_drv, zero_chk, exp_req, ack_now;

    task automatic new_txn(input int m);
        pend[m]    = 1'b1;
        m_we[m]    = 1'($urandom_range(0, 1));
        m_addr[m]  = $urandom;
        m_wdata[m] = $urandom;
    endtask

    initial begin
        i_rst = 1'b0; i_m0_req = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_wdata = '0;
        i_m1_req = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_wdata = '0;
        i_mem_rdata = '0; i_mem_ready = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; m_we[m] = 0; m_addr[m] = 0; m_wdata[m] = 0;
        end
        busy = 0; owner = 0; issue_c = 0; ready_c = -1; ack_c = 0;
        t_we = 0; t_err = 0; t_addr = 0; t_wdata = 0; t_rdata = 0;
        last_g = 1; exp_grant = 0; free_at = 0; n_done = 0; n_issued = 0;
        rst_drv = 0;

        while (n_done < N_TXN && cyc < MAX_CYC) begin
            @(posedge clk);
            cyc++;
            #1;
            zero_chk = 0;
            if (!rst_drv) begin
                busy = 0; last_g = 1; exp_grant = 0; free_at = cyc; zero_chk = 1;
            end
            if (busy && cyc == issue_c) exp_grant = owner;

            exp_req = busy && cyc >= issue_c && cyc < ack_c;
            ack_now = busy && cyc == ack_c;
            check("mem_req",  64'(o_mem_req), 64'(exp_req));
            check("m0_ack",   64'(o_m0_ack), 64'(ack_now && owner == 0));
            check("m1_ack",   64'(o_m1_ack), 64'(ack_now && owner == 1));
            check("m0_rdata", 64'(o_m0_rdata), (ack_now && owner == 0) ? 64'(t_rdata) : 64'd0);
            check("m1_rdata", 64'(o_m1_rdata), (ack_now && owner == 1) ? 64'(t_rdata) : 64'd0);
            check("err",      64'(o_err), 64'(ack_now && t_err));
            check("grant",    64'(o_grant), 64'(exp_grant));
            if (exp_req) begin
                check("mem_we",    64'(o_mem_we), 64'(t_we));
                check("mem_addr",  64'(o_mem_addr), 64'(t_addr));
                check("mem_wdata", 64'(o_mem_wdata), 64'(t_wdata));
            end else if (zero_chk) begin
                check("rst_we",    64'(o_mem_we), 64'd0);
                check("rst_addr",  64'(o_mem_addr), 64'd0);
                check("rst_wdata", 64'(o_mem_wdata), 64'd0);
            end

            rst_drv = 1;
            if (cyc < 3)
                rst_drv = 0;
            else if (busy && cyc > issue_c && cyc < ack_c &&
                     ((n_issued % 16 == 7 && cyc == issue_c + 2) || $urandom_range(0, 99) < 2))
                rst_drv = 0;

            if (ack_now) begin
                pend[owner] = 0;
                last_g  = owner;
                busy    = 0;
                free_at = cyc + 1;
                n_done++;
                if ($urandom_range(0, 1) == 1) new_txn(owner);
            end

            // Withdrawn requests and post-latch field changes must not disturb the transfer
            if (busy && cyc >= issue_c && rst_drv) begin
                if (pend[owner] && $urandom_range(0, 99) < 5) pend[owner] = 0;
                if ($urandom_range(0, 99) < 10) begin
                    m_we[owner] = ~m_we[owner]; m_addr[owner] = $urandom; m_wdata[owner] = $urandom;
                end
            end

            for (int m = 0; m < 2; m++)
                if (!pend[m] && !(busy && owner == m) && $urandom_range(0, 99) < 40) new_txn(m);

            i_m0_req = pend[0]; i_m0_we = m_we[0]; i_m0_addr = m_addr[0]; i_m0_wdata = m_wdata[0];
            i_m1_req = pend[1]; i_m1_we = m_we[1]; i_m1_addr = m_addr[1]; i_m1_wdata = m_wdata[1];

            if (!busy && rst_drv && cyc >= free_at && (pend[0] || pend[1])) begin
                owner   = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
                t_we    = m_we[owner];
                t_addr  = m_addr[owner];
                t_wdata = m_wdata[owner];
                t_rdata = 0;
                issue_c = cyc + 1;
                j = $urandom_range(0, 9);
                if (j < 2)       j = 0;
                else if (j == 2) j = TMO_LIM;
                else             j = $urandom_range(1, 4);
                if (j == 0) begin
                    ready_c = -1;
                    ack_c   = issue_c + TMO_LIM + 1;
                    t_err   = 1;
                end else begin
                    ready_c = issue_c + j;
                    ack_c   = ready_c + 1;
                    t_err   = 0;
                end
                busy = 1;
                n_issued++;
            end

            i_mem_rdata = $urandom;
            if (busy && cyc == ready_c) begin
                i_mem_ready = 1;
                t_rdata     = t_we ? 32'd0 : i_mem_rdata;
            end else if (busy && cyc > issue_c && cyc < ack_c) begin
                i_mem_ready = 0;
            end else begin
                i_mem_ready = ($urandom_range(0, 3) == 0);
            end
            i_rst = rst_drv;
        end

        if (cyc >= MAX_CYC) check("txn_budget", 64'(n_done), 64'(N_TXN));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
